seg_pattern_decoder: RTL and testbench

- Receive end of the seven-segment display interface: takes active-low segment patterns as they are driven to a DE1-SoC HEX display and recovers the 4-bit hex value for each display position.
- Sits beside the display drivers as a self-check/monitor path.
- Debounces each digit position with a stability counter.
- Emits each accepted change through a valid/ready output with a one-entry skid register.

---
 rtl/seg_pattern_decoder_pkg.sv | 20 ++
 rtl/seg_glyph_lookup.sv | 21 ++
 rtl/seg_pattern_decoder.sv | 148 ++++++++++++++
 tb/tb_seg_pattern_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pattern_decoder_pkg.sv
// Shared types and glyph table for the seven-segment pattern decoder.
package seg_pkg;

    localparam int SEG_W     = 7;
    // Result index width; matches the default six-position display.
    localparam int SEG_IDX_W = 3;

    // Active-high glyphs, entry i is the pattern for hex value i.
    localparam logic [15:0][SEG_W-1:0] SEG_GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [3:0]           digit;
        logic [SEG_IDX_W-1:0] idx;
        logic                 legal;
    } seg_result_t;

endpackage

// File: rtl/seg_glyph_lookup.sv
// Combinational reverse lookup: active-high segment pattern to hex digit.
module seg_glyph_lookup
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] pat,
    output logic [3:0]       digit,
    output logic             legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_GLYPHS[i]) begin
                digit = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Monitors HEX display segment drives, debounces each position and emits
// decoded digits over valid/ready. Optional SEG_ERR_COUNT_EN adds err_count.
module seg_pattern_decoder
    import seg_pkg::*;
#(
    parameter  int NUM_DIGITS = 6,
    parameter  int STABLE_CNT = 3,
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEG_W-1:0] seg_in,
    input  logic             seg_strobe,
    input  logic [IDX_W-1:0] seg_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_digit,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_legal,
    output logic             overflow
`ifdef SEG_ERR_COUNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam logic [IDX_W:0] NUM_D  = (IDX_W + 1)'(NUM_DIGITS);
    localparam logic [3:0]     STABLE = 4'(STABLE_CNT);

    logic [SEG_W-1:0]  hist_p0 [NUM_DIGITS];
    logic [3:0]        cnt_p0  [NUM_DIGITS];

    logic [SEG_W-1:0]  pat_p0;
    logic              in_range_p0;
    logic              same_p0;
    logic              acc_p0;
    logic [3:0]        dig_p0;
    logic              leg_p0;
    seg_result_t       res_p0;

    seg_result_t       out_res_p1;
    logic              vld_p1;
    seg_result_t       skid_p1;
    logic              skid_vld_p1;
    logic              ovf_p1;
    logic              xfer_p1;

    // Stage 0: capture, history compare and accept decision
    always_comb begin
        pat_p0      = ~seg_in;
        in_range_p0 = seg_strobe && ({1'b0, seg_idx} < NUM_D);
        same_p0     = 1'b0;
        acc_p0      = 1'b0;
        if (in_range_p0) begin
            same_p0 = (pat_p0 == hist_p0[seg_idx]);
            // Accept only on the strobe that brings the count up to STABLE.
            acc_p0  = same_p0 ? (cnt_p0[seg_idx] == STABLE - 4'd1)
                              : (STABLE == 4'd1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hist_p0[i] <= '0;
                cnt_p0[i]  <= 4'd0;
            end
        end else if (in_range_p0) begin
            if (same_p0) begin
                if (cnt_p0[seg_idx] < STABLE)
                    cnt_p0[seg_idx] <= cnt_p0[seg_idx] + 4'd1;
            end else begin
                hist_p0[seg_idx] <= pat_p0;
                cnt_p0[seg_idx]  <= 4'd1;
            end
        end
    end

    seg_glyph_lookup u_lookup (
        .pat   (pat_p0),
        .digit (dig_p0),
        .legal (leg_p0)
    );

    always_comb begin
        res_p0.digit = dig_p0;
        res_p0.idx   = SEG_IDX_W'(seg_idx);
        res_p0.legal = leg_p0;
    end

    // Stage 1: output register with one-entry skid behind it
    assign xfer_p1 = vld_p1 && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1      <= 1'b0;
            out_res_p1  <= '0;
            skid_vld_p1 <= 1'b0;
            skid_p1     <= '0;
            ovf_p1      <= 1'b0;
        end else if (!vld_p1) begin
            if (acc_p0) begin
                out_res_p1 <= res_p0;
                vld_p1     <= 1'b1;
            end
        end else if (xfer_p1) begin
            if (skid_vld_p1) begin
                out_res_p1 <= skid_p1;
                if (acc_p0)
                    skid_p1 <= res_p0;
                else
                    skid_vld_p1 <= 1'b0;
            end else if (acc_p0) begin
                out_res_p1 <= res_p0;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (acc_p0) begin
            if (!skid_vld_p1) begin
                skid_p1     <= res_p0;
                skid_vld_p1 <= 1'b1;
            end else begin
                ovf_p1 <= 1'b1;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_digit = out_res_p1.digit;
    assign out_idx   = out_res_p1.idx[IDX_W-1:0];
    assign out_legal = out_res_p1.legal;
    assign overflow  = ovf_p1;

`ifdef SEG_ERR_COUNT_EN
    logic [7:0] err_cnt_p1;

    // Counts every accepted illegal pattern, including ones later dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt_p1 <= 8'd0;
        else if (acc_p0 && !leg_p0 && err_cnt_p1 != 8'hFF)
            err_cnt_p1 <= err_cnt_p1 + 8'd1;
    end

    assign err_count = err_cnt_p1;
`endif

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Randomized bench for seg_pattern_decoder with a queue-based reference model.
module tb_seg_pattern_decoder;

    localparam int NUM_DIGITS = 6;
    localparam int STABLE_CNT = 3;
    localparam int IDX_W      = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [6:0]       seg_in;
    logic             seg_strobe;
    logic [IDX_W-1:0] seg_idx;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_digit;
    logic [IDX_W-1:0] out_idx;
    logic             out_legal;
    logic             overflow;
`ifdef SEG_ERR_COUNT_EN
    logic [7:0]       err_count;
`endif

    seg_pattern_decoder #(.NUM_DIGITS(NUM_DIGITS), .STABLE_CNT(STABLE_CNT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_in     (seg_in),
        .seg_strobe (seg_strobe),
        .seg_idx    (seg_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digit  (out_digit),
        .out_idx    (out_idx),
        .out_legal  (out_legal),
        .overflow   (overflow)
`ifdef SEG_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int glyph [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    typedef struct {
        int digit;
        int idx;
        bit legal;
    } res_t;

    // Reference state: per-position last pattern and run length, plus the
    // delivery queue (at most two results can be held at once).
    int   m_hist [8];
    int   m_cnt  [8];
    res_t q [$];
    bit   m_ovf;
    int   m_err;

    int   total_cnt = 0;
    int   pass_cnt  = 0;
    bit   chk_en    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_hist[i] = 0;
            m_cnt[i]  = 0;
        end
        q.delete();
        m_ovf = 1'b0;
        m_err = 0;
    endtask

    // Effect of the next rising edge given the inputs about to be sampled.
    task automatic model_step(input bit s, input logic [6:0] seg, input int idx, input bit r);
        bit   acc = 1'b0;
        int   pat;
        res_t res;
        if (s && idx < NUM_DIGITS) begin
            pat = (~seg) & 'h7F;
            if (pat == m_hist[idx]) begin
                if (m_cnt[idx] < STABLE_CNT) begin
                    m_cnt[idx]++;
                    acc = (m_cnt[idx] == STABLE_CNT);
                end
            end else begin
                m_hist[idx] = pat;
                m_cnt[idx]  = 1;
                acc = (STABLE_CNT == 1);
            end
            if (acc) begin
                res.digit = 0;
                res.legal = 1'b0;
                res.idx   = idx;
                for (int g = 0; g < 16; g++)
                    if (glyph[g] == pat) begin
                        res.digit = g;
                        res.legal = 1'b1;
                    end
            end
        end
        if (q.size() > 0 && r) void'(q.pop_front());
        if (acc) begin
            if (!res.legal && m_err < 255) m_err++;
            if (q.size() < 2) q.push_back(res);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input bit s, input logic [6:0] seg, input int idx, input bit r);
        seg_strobe = s;
        seg_in     = seg;
        seg_idx    = idx[IDX_W-1:0];
        out_ready  = r;
        model_step(s, seg, idx, r);
        @(negedge clk);
    endtask

    task automatic strobe_n(input int n, input logic [6:0] seg, input int idx, input bit r);
        for (int k = 0; k < n; k++) step(1'b1, seg, idx, r);
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("valid", int'(out_valid), int'(q.size() > 0));
            if (q.size() > 0) begin
                chk("digit", int'(out_digit), q[0].digit);
                chk("idx",   int'(out_idx),   q[0].idx);
                chk("legal", int'(out_legal), int'(q[0].legal));
            end
            chk("overflow", int'(overflow), int'(m_ovf));
`ifdef SEG_ERR_COUNT_EN
            chk("err_count", int'(err_count), m_err);
`endif
        end
    end

    initial begin
        logic [6:0] cur [8];
        int         ix;
        reset_n    = 1'b0;
        seg_in     = 7'h7F;
        seg_strobe = 1'b0;
        seg_idx    = '0;
        out_ready  = 1'b1;
        model_reset();
        chk_en     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid",    int'(out_valid), 0);
        chk("rst_digit",    int'(out_digit), 0);
        chk("rst_idx",      int'(out_idx),   0);
        chk("rst_legal",    int'(out_legal), 0);
        chk("rst_overflow", int'(overflow),  0);
        reset_n = 1'b1;

        // Stable '0' on position 0, then a repeat that must not re-emit.
        strobe_n(2, 7'h40, 0, 1'b1);
        chk("lit0_early", int'(out_valid), 0);
        strobe_n(1, 7'h40, 0, 1'b1);
        chk("lit0_valid", int'(out_valid), 1);
        chk("lit0_digit", int'(out_digit), 0);
        chk("lit0_legal", int'(out_legal), 1);
        chk("lit0_idx",   int'(out_idx),   0);
        strobe_n(1, 7'h40, 0, 1'b1);
        chk("lit0_norepeat", int'(out_valid), 0);

        // Bounce then settle on '2' at position 2.
        step(1'b1, 7'h79, 2, 1'b1);
        strobe_n(3, 7'h24, 2, 1'b1);
        chk("bounce_valid", int'(out_valid), 1);
        chk("bounce_digit", int'(out_digit), 2);
        chk("bounce_idx",   int'(out_idx),   2);

        // Blank pattern is illegal.
        strobe_n(3, 7'h7F, 1, 1'b1);
        chk("blank_valid", int'(out_valid), 1);
        chk("blank_digit", int'(out_digit), 0);
        chk("blank_legal", int'(out_legal), 0);
`ifdef SEG_ERR_COUNT_EN
        chk("blank_errcnt", int'(err_count), 1);
`endif
        step(1'b0, 7'h7F, 0, 1'b1);

        // Back-pressure: '1' held, '3' in skid, '4' dropped.
        strobe_n(3, 7'h79, 0, 1'b0);
        strobe_n(3, 7'h30, 1, 1'b0);
        strobe_n(3, 7'h19, 2, 1'b0);
        chk("bp_hold_digit", int'(out_digit), 1);
        chk("bp_hold_idx",   int'(out_idx),   0);
        chk("bp_overflow",   int'(overflow),  1);
        step(1'b0, 7'h7F, 0, 1'b1);
        chk("bp_skid_valid", int'(out_valid), 1);
        chk("bp_skid_digit", int'(out_digit), 3);
        chk("bp_skid_idx",   int'(out_idx),   1);
        step(1'b0, 7'h7F, 0, 1'b1);
        chk("bp_drained", int'(out_valid), 0);

        // Asynchronous reset while output and skid are both full.
        strobe_n(3, 7'h79, 3, 1'b0);
        strobe_n(3, 7'h30, 4, 1'b0);
        chk("stall_valid", int'(out_valid), 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_valid",    int'(out_valid), 0);
        chk("async_overflow", int'(overflow),  0);
        @(negedge clk);
        reset_n = 1'b1;
        strobe_n(3, 7'h40, 0, 1'b1);
        chk("postrst_valid", int'(out_valid), 1);
        chk("postrst_digit", int'(out_digit), 0);

        // Out-of-range positions are ignored entirely.
        strobe_n(4, 7'h40, 7, 1'b1);
        strobe_n(3, 7'h40, 6, 1'b1);
        chk("oor_valid", int'(out_valid), 0);
        strobe_n(3, 7'h40, 5, 1'b1);
        chk("idx5_valid", int'(out_valid), 1);
        chk("idx5_idx",   int'(out_idx),   5);
        chk("idx5_digit", int'(out_digit), 0);

        // Random traffic: sticky per-position patterns so runs complete.
        for (int i = 0; i < 8; i++) cur[i] = 7'(~glyph[$urandom_range(15)]);
        for (int c = 0; c < 3000; c++) begin
            ix = int'($urandom_range(7));
            if ($urandom_range(7) == 0) begin
                if ($urandom_range(3) == 0) cur[ix] = 7'($urandom);
                else cur[ix] = 7'(~glyph[$urandom_range(15)]);
            end
            step(($urandom_range(3) != 0), cur[ix], ix, ($urandom_range(9) < 6));
        end
        for (int c = 0; c < 4; c++) step(1'b0, 7'h7F, 0, 1'b1);
        chk("final_drained", int'(out_valid), 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
